// File: rtl/lock_session_ctrl.sv
// lock_session_ctrl: session sequencer sitting in front of the 8-bit digital lock.
// Collects two keypad nibbles into a code, strobes it into the lock, classifies
// the lock's answer, and times the access window and the lockout penalty before
// pulsing lock_rst to re-arm the lock. At top level the lock's reset is rst | lock_rst.
//
// Optional feature: define MANUAL_RELOCK_EN to add the relock_req input, which
// ends an access window early. Without it, OPEN always runs the full window.
module lock_session_ctrl #(
  parameter int unsigned ACCESS_CYCLES  = 1000,
  parameter int unsigned LOCKOUT_CYCLES = 5000,
  parameter int unsigned ENTRY_TIMEOUT  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_nibble,
  input  logic       key_clear,
  input  logic       access_in,
  input  logic       alarm_in,
  input  logic       lockout_in,
`ifdef MANUAL_RELOCK_EN
  input  logic       relock_req,
`endif
  output logic [7:0] key_out,
  output logic       enter_out,
  output logic       lock_rst,
  output logic       door_open,
  output logic       locked_out,
  output logic       access_fail,
  output logic       entry_abort,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIGIT1,
    S_SUBMIT,
    S_WAIT_RESP,
    S_OPEN,
    S_LOCKOUT,
    S_RELOCK
  } state_e;

  // Counters hold "cycles already spent" in a state, so the last cycle of an
  // N-cycle window is the one where the counter reads N-1.
  localparam logic [31:0] AccessLast  = 32'(ACCESS_CYCLES - 1);
  localparam logic [31:0] LockoutLast = 32'(LOCKOUT_CYCLES - 1);
  localparam logic [31:0] EntryLimit  = 32'(ENTRY_TIMEOUT);

  state_e      state_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [7:0]  key_out_q;
  logic        enter_q;
  logic        lock_rst_q;
  logic        door_open_q;
  logic        locked_out_q;
  logic        access_fail_q;
  logic        entry_abort_q;
  logic        busy_q;

  logic        manual_relock;
  logic        entry_timeout_hit;
  logic        access_done;
  logic        lockout_done;

`ifdef MANUAL_RELOCK_EN
  assign manual_relock = relock_req;
`else
  assign manual_relock = 1'b0;
`endif

  // Saturating increment of the shared counter plus the window-end decodes.
  always_comb begin
    cnt_d             = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    entry_timeout_hit = (cnt_d == EntryLimit);
    access_done       = (cnt_q == AccessLast);
    lockout_done      = (cnt_q == LockoutLast);
  end

  // Session FSM with every output registered and set on the transition into
  // the state that owns it, so the outputs line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 32'd0;
      key_out_q     <= 8'h00;
      enter_q       <= 1'b0;
      lock_rst_q    <= 1'b0;
      door_open_q   <= 1'b0;
      locked_out_q  <= 1'b0;
      access_fail_q <= 1'b0;
      entry_abort_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      enter_q       <= 1'b0;
      lock_rst_q    <= 1'b0;
      access_fail_q <= 1'b0;
      entry_abort_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (key_valid) begin
            key_out_q <= {key_nibble, 4'h0};
            cnt_q     <= 32'd0;
            busy_q    <= 1'b1;
            state_q   <= S_DIGIT1;
          end
        end

        S_DIGIT1: begin
          if (key_clear) begin
            key_out_q     <= 8'h00;
            entry_abort_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end else if (key_valid) begin
            key_out_q[3:0] <= key_nibble;
            enter_q        <= 1'b1;
            state_q        <= S_SUBMIT;
          end else if (entry_timeout_hit) begin
            key_out_q     <= 8'h00;
            entry_abort_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_SUBMIT: begin
          state_q <= S_WAIT_RESP;
        end

        S_WAIT_RESP: begin
          if (access_in) begin
            cnt_q       <= 32'd0;
            door_open_q <= 1'b1;
            state_q     <= S_OPEN;
          end else if (lockout_in) begin
            cnt_q         <= 32'd0;
            locked_out_q  <= 1'b1;
            access_fail_q <= 1'b1;
            state_q       <= S_LOCKOUT;
          end else if (alarm_in) begin
            access_fail_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        S_OPEN: begin
          if (access_done || manual_relock) begin
            door_open_q <= 1'b0;
            lock_rst_q  <= 1'b1;
            key_out_q   <= 8'h00;
            state_q     <= S_RELOCK;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_LOCKOUT: begin
          if (lockout_done) begin
            locked_out_q <= 1'b0;
            lock_rst_q   <= 1'b1;
            key_out_q    <= 8'h00;
            state_q      <= S_RELOCK;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_RELOCK: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          key_out_q    <= 8'h00;
          door_open_q  <= 1'b0;
          locked_out_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign key_out     = key_out_q;
  assign enter_out   = enter_q;
  assign lock_rst    = lock_rst_q;
  assign door_open   = door_open_q;
  assign locked_out  = locked_out_q;
  assign access_fail = access_fail_q;
  assign entry_abort = entry_abort_q;
  assign busy        = busy_q;

  // The strobes and windows are only ever visible in the state that owns them.
  a_enter_in_submit : assert property (@(posedge clk) disable iff (rst)
    enter_out |-> (state_q == S_SUBMIT));
  a_rst_in_relock : assert property (@(posedge clk) disable iff (rst)
    lock_rst |-> (state_q == S_RELOCK));
  a_open_xor_lock : assert property (@(posedge clk) disable iff (rst)
    !(door_open && locked_out));

endmodule

// File: tb/tb_lock_session_ctrl.sv
// tb_lock_session_ctrl: directed bench for lock_session_ctrl with a small
// behavioural model of the 8-bit lock (password A5, three attempts).
module tb_lock_session_ctrl;

`ifdef MANUAL_RELOCK_EN
  localparam int ACC = 100;
`else
  localparam int ACC = 4;
`endif
  localparam int LOCK_CYC = 6;
  localparam int ENTRY_TO = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_nibble = 4'h0;
  logic       key_clear = 1'b0;
  logic       access_in = 1'b0;
  logic       alarm_in = 1'b0;
  logic       lockout_in = 1'b0;
`ifdef MANUAL_RELOCK_EN
  logic       relock_req = 1'b0;
`endif
  logic [7:0] key_out;
  logic       enter_out;
  logic       lock_rst;
  logic       door_open;
  logic       locked_out;
  logic       access_fail;
  logic       entry_abort;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int enterCount = 0;
  int failCount = 0;
  int lockRstCount = 0;
  int doorCycles = 0;

  logic [1:0] attempts = 2'd0;

  lock_session_ctrl #(
    .ACCESS_CYCLES (ACC),
    .LOCKOUT_CYCLES(LOCK_CYC),
    .ENTRY_TIMEOUT (ENTRY_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_nibble (key_nibble),
    .key_clear  (key_clear),
    .access_in  (access_in),
    .alarm_in   (alarm_in),
    .lockout_in (lockout_in),
`ifdef MANUAL_RELOCK_EN
    .relock_req (relock_req),
`endif
    .key_out    (key_out),
    .enter_out  (enter_out),
    .lock_rst   (lock_rst),
    .door_open  (door_open),
    .locked_out (locked_out),
    .access_fail(access_fail),
    .entry_abort(entry_abort),
    .busy       (busy)
  );

  initial forever #5 clk = ~clk;

  // Behavioural lock: latches access on the right code, pulses alarm on a
  // wrong one and latches lockout on the third wrong code; cleared by rst | lock_rst.
  always @(posedge clk) begin
    alarm_in <= 1'b0;
    if (rst || lock_rst) begin
      access_in  <= 1'b0;
      lockout_in <= 1'b0;
      attempts   <= 2'd0;
    end else if (enter_out && !lockout_in) begin
      if (key_out == 8'hA5) begin
        access_in <= 1'b1;
      end else begin
        alarm_in <= 1'b1;
        if (attempts == 2'd2) lockout_in <= 1'b1;
        attempts <= attempts + 2'd1;
      end
    end
  end

  // Event counters sampled mid-cycle for "never / exactly once" checks.
  always @(negedge clk) begin
    if (enter_out)   enterCount   <= enterCount + 1;
    if (access_fail) failCount    <= failCount + 1;
    if (lock_rst)    lockRstCount <= lockRstCount + 1;
    if (door_open)   doorCycles   <= doorCycles + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] n, input logic c);
    key_valid  = v;
    key_nibble = n;
    key_clear  = c;
    stepCycle();
    key_valid = 1'b0;
    key_clear = 1'b0;
  endtask

  task automatic enterCode(input logic [7:0] code);
    applyStimulus(1'b1, code[7:4], 1'b0);
    applyStimulus(1'b1, code[3:0], 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    stepCycle();
    stepCycle();
    rst = 1'b0;
  endtask

  int e0, f0, r0, d0;

  initial begin
    // Reset state
    stepCycle();
    stepCycle();
    checkOutput("rst_key",   key_out, 8'h00);
    checkOutput("rst_enter", enter_out, 0);
    checkOutput("rst_lrst",  lock_rst, 0);
    checkOutput("rst_door",  door_open, 0);
    checkOutput("rst_lock",  locked_out, 0);
    checkOutput("rst_fail",  access_fail, 0);
    checkOutput("rst_abort", entry_abort, 0);
    checkOutput("rst_busy",  busy, 0);
    rst = 1'b0;
    stepCycle();

    // key_clear in IDLE does nothing
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("idle_clr_abort", entry_abort, 0);
    checkOutput("idle_clr_busy",  busy, 0);

    // Correct code A5 opens for ACC cycles then re-arms
    e0 = enterCount; r0 = lockRstCount;
    applyStimulus(1'b1, 4'hA, 1'b0);
    checkOutput("A_d1_busy", busy, 1);
    applyStimulus(1'b1, 4'h5, 1'b0);
    checkOutput("A_enter", enter_out, 1);
    checkOutput("A_key",   key_out, 8'hA5);
    stepCycle();
    checkOutput("A_enter_once", enter_out, 0);
    checkOutput("A_door_wait",  door_open, 0);
    stepCycle();
    for (int i = 0; i < ACC; i++) begin
      checkOutput("A_door", door_open, 1);
      stepCycle();
    end
    checkOutput("A_door_end", door_open, 0);
    checkOutput("A_lrst",     lock_rst, 1);
    checkOutput("A_key_clr",  key_out, 8'h00);
    stepCycle();
    checkOutput("A_lrst_once", lock_rst, 0);
    checkOutput("A_busy_end",  busy, 0);
    checkOutput("A_lock_acc",  access_in, 0);
    checkOutput("A_enters",    32'(enterCount - e0), 1);
    checkOutput("A_lrsts",     32'(lockRstCount - r0), 1);

    // Wrong code 3C: access_fail two cycles after enter, no door
    e0 = enterCount; d0 = doorCycles; f0 = failCount;
    enterCode(8'h3C);
    checkOutput("B_enter", enter_out, 1);
    checkOutput("B_key",   key_out, 8'h3C);
    stepCycle();
    checkOutput("B_fail_early", access_fail, 0);
    stepCycle();
    checkOutput("B_fail", access_fail, 1);
    checkOutput("B_busy", busy, 0);
    stepCycle();
    checkOutput("B_fail_once", access_fail, 0);
    checkOutput("B_nodoor", 32'(doorCycles - d0), 0);
    checkOutput("B_fails",  32'(failCount - f0), 1);

    // Three wrong codes from a fresh lock: two alarms then lockout
    doReset();
    f0 = failCount;
    for (int k = 0; k < 2; k++) begin
      enterCode(8'h12);
      stepCycle();
      stepCycle();
      checkOutput("C_fail",     access_fail, 1);
      checkOutput("C_nolock",   locked_out, 0);
      checkOutput("C_idle",     busy, 0);
      stepCycle();
    end
    enterCode(8'h77);
    stepCycle();
    stepCycle();
    e0 = enterCount; r0 = lockRstCount;
    for (int i = 0; i < LOCK_CYC; i++) begin
      checkOutput("C_locked",   locked_out, 1);
      checkOutput("C_fail_one", access_fail, (i == 0) ? 1 : 0);
      checkOutput("C_busy",     busy, 1);
      key_valid  = 1'b1;
      key_nibble = 4'(i);
      stepCycle();
    end
    key_valid = 1'b0;
    checkOutput("C_lock_end", locked_out, 0);
    checkOutput("C_lrst",     lock_rst, 1);
    stepCycle();
    checkOutput("C_busy_end",  busy, 0);
    checkOutput("C_fails",     32'(failCount - f0), 3);
    checkOutput("C_noenter",   32'(enterCount - e0), 0);
    checkOutput("C_lrsts",     32'(lockRstCount - r0), 1);

    // Re-armed lock accepts A5; keys during OPEN are ignored
    d0 = doorCycles;
    enterCode(8'hA5);
    stepCycle();
    stepCycle();
    e0 = enterCount;
    checkOutput("C_open", door_open, 1);
    applyStimulus(1'b1, 4'h3, 1'b0);
    applyStimulus(1'b1, 4'hC, 1'b0);
    checkOutput("C_key_hold", key_out, 8'hA5);
    for (int i = 2; i < ACC; i++) stepCycle();
    checkOutput("C_lrst2",    lock_rst, 1);
    checkOutput("C_doorcyc",  32'(doorCycles - d0), ACC);
    stepCycle();
    checkOutput("C_open_noenter", 32'(enterCount - e0), 0);
    checkOutput("C_idle2", busy, 0);

    // Entry timeout after ENTRY_TO idle cycles in DIGIT1
    e0 = enterCount;
    applyStimulus(1'b1, 4'hA, 1'b0);
    for (int i = 0; i < ENTRY_TO; i++) begin
      checkOutput("D_wait_busy",  busy, 1);
      checkOutput("D_wait_abort", entry_abort, 0);
      stepCycle();
    end
    checkOutput("D_abort",   entry_abort, 1);
    checkOutput("D_busy",    busy, 0);
    checkOutput("D_key_clr", key_out, 8'h00);
    stepCycle();
    checkOutput("D_abort_once", entry_abort, 0);

    // key_clear wins over a simultaneous second nibble
    applyStimulus(1'b1, 4'hA, 1'b0);
    applyStimulus(1'b1, 4'h5, 1'b1);
    checkOutput("D_clr_abort", entry_abort, 1);
    checkOutput("D_clr_enter", enter_out, 0);
    checkOutput("D_clr_key",   key_out, 8'h00);
    stepCycle();
    checkOutput("D_noenter", 32'(enterCount - e0), 0);

    // rst in the middle of OPEN clears everything with no lock_rst
    enterCode(8'hA5);
    stepCycle();
    stepCycle();
    checkOutput("E_open", door_open, 1);
    r0 = lockRstCount;
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("E_door", door_open, 0);
    checkOutput("E_busy", busy, 0);
    checkOutput("E_key",  key_out, 8'h00);
    checkOutput("E_lrst", lock_rst, 0);
    stepCycle();
    stepCycle();
    checkOutput("E_nolrst", 32'(lockRstCount - r0), 0);
    checkOutput("E_idle",   busy, 0);

`ifdef MANUAL_RELOCK_EN
    // relock_req in the 3rd OPEN cycle ends the window early
    d0 = doorCycles;
    enterCode(8'hA5);
    stepCycle();
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("M_open3", door_open, 1);
    relock_req = 1'b1;
    stepCycle();
    relock_req = 1'b0;
    checkOutput("M_lrst", lock_rst, 1);
    checkOutput("M_door", door_open, 0);
    checkOutput("M_doorcyc", 32'(doorCycles - d0), 3);
    stepCycle();
    checkOutput("M_idle", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
